// File: rtl/csa_tree_pipe_if.sv
// Operand-set / result handshake bundle for csa_tree_pipe.
// OUT_W is derived here so both ends agree on the result width.
interface csa_tree_pipe_if #(
  parameter int N     = 32,
  parameter int W     = 64,
  parameter int TAG_W = 8
);
  localparam int OUT_W = W + $clog2(N);

  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     in_data;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_sum;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag
  );
endinterface

// File: rtl/csa_tree_pipe.sv
// Pipelined N-operand adder: registered 3:2 carry-save levels, then a registered
// carry-propagate add. Whole pipe stalls when the result is held by the sink.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);
  assign s  = a ^ b ^ c;
  // carry row is pre-shifted; the carry out of the top bit is dropped (mod 2^W)
  assign cy = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
endmodule

module csa_tree_pipe #(
  parameter int N      = 32,
  parameter int W      = 64,
  parameter int TAG_W  = 8,
  parameter int SIGNED = 0
) (
  input logic           clock,
  input logic           reset,
  csa_tree_pipe_if.slave bus
);
  localparam int OUT_W = W + $clog2(N);

  function automatic int rows_after(input int lv);
    int n = N;
    for (int i = 0; i < lv; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int num_levels();
    int n = N;
    int l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  localparam int L = num_levels();

  if (N < 2 || W < 1) begin : g_bad_cfg
    $error("csa_tree_pipe: N must be >= 2 and W >= 1");
  end

  logic                stall;
  logic [L:0]          vld_pipe;
  logic [TAG_W-1:0]    tag_pipe [0:L];
  logic [OUT_W-1:0]    ext [N];
  logic [OUT_W-1:0]    fa, fb, sum_q;

  // stall depends only on the registered output valid, so in_ready has no path from in_valid
  assign stall         = vld_pipe[L] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_pipe[L];
  assign bus.out_tag   = tag_pipe[L];
  assign bus.out_sum   = sum_q;

  for (genvar k = 0; k < N; k++) begin : g_ext
    logic [W-1:0] op;
    assign op     = bus.in_data[k*W +: W];
    assign ext[k] = {{(OUT_W-W){(SIGNED != 0) ? op[W-1] : 1'b0}}, op};
  end

  for (genvar l = 0; l < L; l++) begin : lvl
    localparam int NI = rows_after(l);
    localparam int NO = rows_after(l + 1);
    localparam int G  = NI / 3;

    logic [OUT_W-1:0] src [NI];
    logic [OUT_W-1:0] nxt [NO];
    logic [OUT_W-1:0] q   [NO];

    if (l == 0) begin : g_first
      assign src = ext;
    end else begin : g_next
      assign src = lvl[l-1].q;
    end

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_row #(.W(OUT_W)) u_csa (
        .a  (src[3*g]),
        .b  (src[3*g+1]),
        .c  (src[3*g+2]),
        .s  (nxt[2*g]),
        .cy (nxt[2*g+1])
      );
    end

    for (genvar r = 0; r < NI % 3; r++) begin : g_pass
      assign nxt[2*G + r] = src[3*G + r];
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < NO; i++) q[i] <= '0;
      end else if (!stall) begin
        for (int i = 0; i < NO; i++) q[i] <= nxt[i];
      end
    end
  end

  if (L == 0) begin : g_fin_direct
    assign fa = ext[0];
    assign fb = ext[1];
  end else begin : g_fin_tree
    assign fa = lvl[L-1].q[0];
    assign fb = lvl[L-1].q[1];
  end

  // vld_pipe[i]/tag_pipe[i] track CSA level i; index L is the output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i <= L; i++) tag_pipe[i] <= '0;
      sum_q <= '0;
    end else if (!stall) begin
      vld_pipe[0] <= bus.in_valid;
      tag_pipe[0] <= bus.in_tag;
      for (int i = 1; i <= L; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      sum_q <= fa + fb;
    end
  end
endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: four configurations, table of vectors with a
// scoreboard, plus hand sequences for stall hold and asynchronous reset.
module tb_csa_tree_pipe;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  csa_tree_pipe_if #(.N(32), .W(64), .TAG_W(8)) b32 ();
  csa_tree_pipe_if #(.N(4),  .W(8),  .TAG_W(8)) bu ();
  csa_tree_pipe_if #(.N(4),  .W(8),  .TAG_W(8)) bs ();
  csa_tree_pipe_if #(.N(2),  .W(16), .TAG_W(8)) b2 ();

  csa_tree_pipe #(.N(32), .W(64), .TAG_W(8), .SIGNED(0)) u32 (.clock(clock), .reset(reset), .bus(b32.slave));
  csa_tree_pipe #(.N(4),  .W(8),  .TAG_W(8), .SIGNED(0)) u4u (.clock(clock), .reset(reset), .bus(bu.slave));
  csa_tree_pipe #(.N(4),  .W(8),  .TAG_W(8), .SIGNED(1)) u4s (.clock(clock), .reset(reset), .bus(bs.slave));
  csa_tree_pipe #(.N(2),  .W(16), .TAG_W(8), .SIGNED(0)) u2  (.clock(clock), .reset(reset), .bus(b2.slave));

  typedef struct { logic [9:0] sum; logic [7:0] tag; } res_t;
  typedef struct { logic [31:0] ops; logic [7:0] tag; logic [9:0] exp_u; logic [9:0] exp_s; } vec_t;

  res_t q_u[$];
  res_t q_s[$];
  int   pop_cyc[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboards: a transfer happens at the next posedge when valid & ready here
  always @(negedge clock) begin
    if (!reset && bu.out_valid && bu.out_ready) begin
      res_t e;
      if (q_u.size() == 0) begin
        checks++; errors++;
        $display("FAIL u4u_spurious: got sum %0h tag %0h with nothing expected", bu.out_sum, bu.out_tag);
      end else begin
        e = q_u.pop_front();
        chk("u4u_sum", bu.out_sum, e.sum);
        chk("u4u_tag", bu.out_tag, e.tag);
        pop_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && bs.out_valid && bs.out_ready) begin
      res_t e;
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL u4s_spurious: got sum %0h tag %0h with nothing expected", bs.out_sum, bs.out_tag);
      end else begin
        e = q_s.pop_front();
        chk("u4s_sum", bs.out_sum, e.sum);
        chk("u4s_tag", bs.out_tag, e.tag);
      end
    end
  end

  task automatic send(input logic [31:0] ops, input logic [7:0] tag, input logic [9:0] exp);
    logic ok;
    bu.in_valid = 1'b1;
    bu.in_data  = ops;
    bu.in_tag   = tag;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clock);
      ok = bu.in_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else begin
      q_u.push_back('{exp, tag});
    end
    @(posedge clock); #1;
    bu.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec [8];
    int lat32, latu, lats, lat2, bad;
    logic [68:0] s32;
    logic [7:0]  t32;
    logic [16:0] s2;
    logic ok, hit, seen;

    vec[0] = '{32'h04030201, 8'd1, 10'd10,  10'd10};
    vec[1] = '{32'h281E140A, 8'd2, 10'd100, 10'd100};
    vec[2] = '{32'hFFFFFFFF, 8'd3, 10'd1020, 10'h3FC};
    vec[3] = '{32'h10204080, 8'd4, 10'd240, 10'h3F0};
    vec[4] = '{32'h193264C8, 8'd5, 10'd375, 10'd119};
    vec[5] = '{32'h7F7F7F7F, 8'd6, 10'd508, 10'd508};
    vec[6] = '{32'h00000000, 8'd7, 10'd0,   10'd0};
    vec[7] = '{32'h01FF01FF, 8'd8, 10'd512, 10'd0};

    b32.in_valid = 0; b32.in_data = '0; b32.in_tag = '0; b32.out_ready = 1;
    bu.in_valid  = 0; bu.in_data  = '0; bu.in_tag  = '0; bu.out_ready  = 1;
    bs.in_valid  = 0; bs.in_data  = '0; bs.in_tag  = '0; bs.out_ready  = 1;
    b2.in_valid  = 0; b2.in_data  = '0; b2.in_tag  = '0; b2.out_ready  = 1;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_u4u_valid", bu.out_valid, 0);
    chk("rst_u4u_sum",   bu.out_sum, 0);
    chk("rst_u4u_tag",   bu.out_tag, 0);
    chk("rst_u32_valid", b32.out_valid, 0);
    chk("rst_u32_sum",   b32.out_sum, 0);
    chk("rst_u4u_ready", bu.in_ready, 1);
    #1 reset = 1'b0;

    // latency / width corners on all four configurations at once
    @(posedge clock); #1;
    b32.in_valid = 1; b32.in_data = {32{64'hFFFF_FFFF_FFFF_FFFF}}; b32.in_tag = 8'hA5;
    bu.in_valid  = 1; bu.in_data  = {4{8'd128}};                  bu.in_tag  = 8'h77;
    bs.in_valid  = 1; bs.in_data  = {4{8'h80}};                   bs.in_tag  = 8'h55;
    b2.in_valid  = 1; b2.in_data  = {16'h0001, 16'hFFFF};         b2.in_tag  = 8'h3C;
    q_u.push_back('{10'h200, 8'h77});
    q_s.push_back('{10'h200, 8'h55});
    @(posedge clock); #1;
    b32.in_valid = 0; bu.in_valid = 0; bs.in_valid = 0; b2.in_valid = 0;
    lat32 = 0; latu = 0; lats = 0; lat2 = 0; s32 = '0; t32 = '0; s2 = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) begin @(posedge clock); #1; end
      if (lat32 == 0 && b32.out_valid) begin lat32 = k; s32 = b32.out_sum; t32 = b32.out_tag; end
      if (latu == 0 && bu.out_valid) latu = k;
      if (lats == 0 && bs.out_valid) lats = k;
      if (lat2 == 0 && b2.out_valid) begin lat2 = k; s2 = b2.out_sum; end
    end
    chk("u32_latency", lat32, 9);
    chk("u32_sum",     s32, 69'h1F_FFFF_FFFF_FFFF_FFE0);
    chk("u32_tag",     t32, 8'hA5);
    chk("u4u_latency", latu, 3);
    chk("u4s_latency", lats, 3);
    chk("u2_latency",  lat2, 1);
    chk("u2_sum",      s2, 17'h10000);

    // table vectors, back-to-back into both N=4 instances
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      bu.in_valid = 1; bu.in_data = vec[i].ops; bu.in_tag = vec[i].tag;
      bs.in_valid = 1; bs.in_data = vec[i].ops; bs.in_tag = vec[i].tag;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge clock);
        ok = bu.in_ready && bs.in_ready;
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL tbl_ready_timeout: in_ready stayed 0 at vector %0d, expected 1", i);
      end else begin
        q_u.push_back('{vec[i].exp_u, vec[i].tag});
        q_s.push_back('{vec[i].exp_s, vec[i].tag});
      end
      @(posedge clock); #1;
    end
    bu.in_valid = 0; bs.in_valid = 0;
    repeat (6) @(posedge clock);
    #1;
    chk("tbl_count", pop_cyc.size(), 8);
    bad = 0;
    for (int i = 0; i + 1 < pop_cyc.size(); i++) if (pop_cyc[i+1] - pop_cyc[i] != 1) bad++;
    chk("tbl_back_to_back_gaps", bad, 0);

    // back-pressure: hold the first result for 4 cycles
    pop_cyc.delete();
    fork
      begin
        send(32'h04030201, 8'd1, 10'd10);
        send(32'h281E140A, 8'd2, 10'd100);
        send(32'hFFFFFFFF, 8'd3, 10'd1020);
      end
      begin
        hit = 1'b0;
        for (int n = 0; n < 30 && !hit; n++) begin
          @(posedge clock); #1;
          hit = bu.out_valid;
        end
        if (!hit) begin
          checks++; errors++;
          $display("FAIL stall_first_result: out_valid never rose, expected 1");
        end
        bu.out_ready = 0;
        for (int h = 0; h < 4; h++) begin
          @(negedge clock);
          chk("hold_valid", bu.out_valid, 1);
          chk("hold_sum",   bu.out_sum, 10'd10);
          chk("hold_tag",   bu.out_tag, 8'd1);
          chk("hold_in_ready", bu.in_ready, 0);
          @(posedge clock); #1;
        end
        bu.out_ready = 1;
      end
    join
    repeat (6) @(posedge clock);
    #1;
    chk("stall_count", pop_cyc.size(), 3);
    chk("stall_sb_empty", q_u.size(), 0);

    // asynchronous reset with sets in flight and one on the output
    send(32'h01010101, 8'h09, 10'd4);
    send(32'h02020202, 8'h0A, 10'd8);
    send(32'h03030303, 8'h0B, 10'd12);
    chk("pre_rst_valid", bu.out_valid, 1);
    chk("pre_rst_sum",   bu.out_sum, 10'd4);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", bu.out_valid, 0);
    chk("async_rst_sum",   bu.out_sum, 0);
    chk("async_rst_tag",   bu.out_tag, 0);
    q_u.delete();
    q_s.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clock); #1;
      seen = seen | bu.out_valid;
    end
    chk("post_rst_quiet", seen, 0);
    pop_cyc.delete();
    send(32'h05050505, 8'h20, 10'd20);
    repeat (5) @(posedge clock);
    #1;
    chk("post_rst_count", pop_cyc.size(), 1);
    chk("final_sb_u_empty", q_u.size(), 0);
    chk("final_sb_s_empty", q_s.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
